cheat_engine_mc: RTL



---
 rtl/cheat_engine_mc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cheat_engine_mc.sv
// Cheat-code override engine: 4-word code loader feeding MAX_CODES match slots.
// The highest-index matching slot replaces CPU read data. OUT_REG adds one
// register stage on the override outputs.
module cheat_engine_mc #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CODES  = 8,
    parameter int OUT_REG    = 0,
    localparam int SW = $clog2(MAX_CODES),
    localparam int CW = $clog2(MAX_CODES + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  enable,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [31:0]           wr_data,
    output logic                  load_err,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  available,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  o_genie_ovr,
    output logic [DATA_WIDTH-1:0] o_genie_data,
    output logic [SW-1:0]         o_hit_slot
);

    typedef enum logic [2:0] {W0, W1, W2, W3, COMMIT} state_t;

    state_t state, state_nxt;

    logic        f_cmp, f_en, f_auto;
    logic [5:0]  f_idx;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_cmp, c_rep;

    logic [MAX_CODES-1:0]                 valid, slot_cmp_en, hit;
    logic [MAX_CODES-1:0][ADDR_WIDTH-1:0] slot_addr;
    logic [MAX_CODES-1:0][DATA_WIDTH-1:0] slot_cmp, slot_rep;

    logic          beat, sync_clr;
    logic          free_any, idx_ok, do_write, do_del, commit_err;
    logic [SW-1:0] free_idx, tgt_idx;

    logic                  m_ovr;
    logic [DATA_WIDTH-1:0] m_data;
    logic [SW-1:0]         m_idx;

    assign sync_clr  = !reset_n || clear;
    assign wr_ready  = (state != COMMIT);
    assign beat      = wr_valid && wr_ready;
    assign available = (count != '0);
    assign full      = (count == CW'(MAX_CODES));
    assign idx_ok    = ({26'd0, f_idx} < 32'(MAX_CODES));

    // Loader state register
    always_ff @(posedge clk) begin
        if (sync_clr) state <= W0;
        else          state <= state_nxt;
    end

    // Loader next state: advance on each accepted beat, COMMIT always one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            W0:      if (beat) state_nxt = W1;
            W1:      if (beat) state_nxt = W2;
            W2:      if (beat) state_nxt = W3;
            W3:      if (beat) state_nxt = COMMIT;
            default: state_nxt = W0;
        endcase
    end

    // Capture the code words as they stream in; upper bits are dropped
    always_ff @(posedge clk) begin
        if (beat) begin
            case (state)
                W0: begin
                    f_cmp  <= wr_data[0];
                    f_en   <= wr_data[1];
                    f_auto <= wr_data[2];
                    f_idx  <= wr_data[21:16];
                end
                W1:      c_addr <= wr_data[ADDR_WIDTH-1:0];
                W2:      c_cmp  <= wr_data[DATA_WIDTH-1:0];
                W3:      c_rep  <= wr_data[DATA_WIDTH-1:0];
                default: ;
            endcase
        end
    end

    // Lowest-index free slot for auto allocation
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int i = MAX_CODES - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_any = 1'b1;
                free_idx = SW'(i);
            end
        end
    end

    // Commit decision: write, delete or discard with error
    always_comb begin
        do_write   = 1'b0;
        do_del     = 1'b0;
        commit_err = 1'b0;
        tgt_idx    = f_idx[SW-1:0];
        if (state == COMMIT) begin
            if (f_auto) begin
                if (f_en && free_any) begin
                    do_write = 1'b1;
                    tgt_idx  = free_idx;
                end else begin
                    commit_err = 1'b1;
                end
            end else if (!idx_ok) begin
                commit_err = 1'b1;
            end else if (f_en) begin
                do_write = 1'b1;
            end else begin
                do_del = 1'b1;
            end
        end
    end

    // Slot storage, valid-slot count and the error pulse
    always_ff @(posedge clk) begin
        if (sync_clr) begin
            valid    <= '0;
            count    <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= commit_err;
            if (do_write) begin
                valid[tgt_idx]       <= 1'b1;
                slot_cmp_en[tgt_idx] <= f_cmp;
                slot_addr[tgt_idx]   <= c_addr;
                slot_cmp[tgt_idx]    <= c_cmp;
                slot_rep[tgt_idx]    <= c_rep;
                if (!valid[tgt_idx]) count <= count + CW'(1);
            end else if (do_del) begin
                valid[tgt_idx] <= 1'b0;
                if (valid[tgt_idx]) count <= count - CW'(1);
            end
        end
    end

    for (genvar g = 0; g < MAX_CODES; g++) begin : g_slot
        assign hit[g] = valid[g] && (slot_addr[g] == addr_in) &&
                        (!slot_cmp_en[g] || (slot_cmp[g] == data_in));
    end

    // Priority select: ascending scan so the highest hitting index wins
    always_comb begin
        m_ovr  = 1'b0;
        m_data = '0;
        m_idx  = '0;
        if (enable) begin
            for (int i = 0; i < MAX_CODES; i++) begin
                if (hit[i]) begin
                    m_ovr  = 1'b1;
                    m_data = slot_rep[i];
                    m_idx  = SW'(i);
                end
            end
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        // Registered override outputs, one cycle behind the bus
        always_ff @(posedge clk) begin
            if (sync_clr) begin
                o_genie_ovr  <= 1'b0;
                o_genie_data <= '0;
                o_hit_slot   <= '0;
            end else begin
                o_genie_ovr  <= m_ovr;
                o_genie_data <= m_data;
                o_hit_slot   <= m_idx;
            end
        end
    end else begin : g_ocomb
        assign o_genie_ovr  = m_ovr;
        assign o_genie_data = m_data;
        assign o_hit_slot   = m_idx;
    end

endmodule
